// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_sender_fifo.sv
// Byte FIFO in front of the serialiser; extra pointer wrap bit separates full from empty.
module uart_sender_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // dout holds the most recently popped byte until the next pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        dout   <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_sender.sv
// 8N1 UART transmitter: FIFO-buffered byte input, internal bit-period divider, registered line.
// Handshake: a byte is taken when TX_EN && TX_READY at a rising edge; TX_EN while !TX_READY drops it and pulses OVERRUN.
module uart_sender
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_READY,
  output logic       UART_TX,
  output logic       TX_BUSY,
  output logic       TX_STATUS,
  output logic       OVERRUN
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_t            state;
  tx_state_t            next_state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_push;
  logic       fifo_pop;

  logic bit_end;
  logic line_d;
  logic busy_d;
  logic stop_done;
  logic load_shift;
  logic shift_en;
  logic status_d1;

  assign fifo_push = TX_EN && !fifo_full;
  assign TX_READY  = !fifo_full;
  assign bit_end   = (cnt == CNT_LAST);

  uart_sender_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (TX_DATA),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (!fifo_empty) next_state = S_START;
      S_START: if (bit_end) next_state = S_DATA;
      S_DATA:  if (bit_end && bit_idx == IDX_LAST) next_state = S_STOP;
      S_STOP:  if (bit_end) next_state = fifo_empty ? S_IDLE : S_START;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop   = 1'b0;
    line_d     = 1'b1;
    busy_d     = 1'b1;
    stop_done  = 1'b0;
    load_shift = 1'b0;
    shift_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy_d   = 1'b0;
        fifo_pop = !fifo_empty;
      end
      S_START: begin
        line_d     = 1'b0;
        load_shift = bit_end;
      end
      S_DATA: begin
        line_d   = shift_reg[0];
        shift_en = bit_end;
      end
      S_STOP: begin
        stop_done = bit_end;
        fifo_pop  = bit_end && !fifo_empty;
      end
      default: busy_d = 1'b0;
    endcase
  end

  // The popped byte stays on fifo_dout through START, so it is loaded as START ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if (state == S_IDLE || bit_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load_shift) begin
        shift_reg <= fifo_dout;
      end else if (shift_en) begin
        shift_reg <= shift_reg >> 1;
      end
      if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Line and BUSY lag the state by one cycle; STATUS gets a second stage so it lands
  // in the cycle after the last stop-bit cycle seen on the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      UART_TX   <= 1'b1;
      TX_BUSY   <= 1'b0;
      status_d1 <= 1'b0;
      TX_STATUS <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      UART_TX   <= line_d;
      TX_BUSY   <= busy_d;
      status_d1 <= stop_done;
      TX_STATUS <= status_d1;
      OVERRUN   <= TX_EN && fifo_full;
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// Bench for uart_sender: timeline reference model, line receiver and scoreboard, table and corner sequences.
module tb_uart_sender;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FLEN  = 10 * DIV;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_ovr;
    logic       exp_tx;
    logic       exp_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] TX_DATA;
  logic       TX_EN;
  logic       TX_READY;
  logic       UART_TX;
  logic       TX_BUSY;
  logic       TX_STATUS;
  logic       OVERRUN;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         t        = 0;
  int         last_pop = -1000000;
  logic [7:0] mq[$];
  int         st_q[$];
  int         cur_p, prev_p;
  logic [7:0] cur_b, prev_b;
  bit         cur_v    = 0;
  bit         prev_v   = 0;
  logic       m_tx, m_busy, m_status, m_ovr, m_ready;

  // scoreboard and line receiver
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int         rx_off = -1;
  logic [7:0] rx_sh;

  uart_sender #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .TX_DATA   (TX_DATA),
    .TX_EN     (TX_EN),
    .TX_READY  (TX_READY),
    .UART_TX   (UART_TX),
    .TX_BUSY   (TX_BUSY),
    .TX_STATUS (TX_STATUS),
    .OVERRUN   (OVERRUN)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // Line level of a frame popped at edge p, as seen after edge tt.
  function automatic void frame_at(input int p, input logic [7:0] b, input int tt,
                                   output bit active, output logic v);
    int j;
    int k;
    j = tt - p - 1;
    active = (j >= 0) && (j < FLEN);
    v = 1'b1;
    if (active) begin
      k = j / DIV;
      if (k == 0) v = 1'b0;
      else if (k <= 8) v = b[k-1];
    end
  endfunction

  task automatic model_edge(input logic en, input logic [7:0] d, input logic rst);
    int   pre;
    bit   act;
    logic v;
    t++;
    if (rst) begin
      mq.delete();
      st_q.delete();
      exp_q.delete();
      cur_v    = 0;
      prev_v   = 0;
      last_pop = -1000000;
      m_ovr    = 1'b0;
      rx_off   = -1;
    end else begin
      pre   = mq.size();
      m_ovr = en && (pre == DEPTH);
      if (pre > 0 && t >= last_pop + FLEN) begin
        prev_p   = cur_p;
        prev_b   = cur_b;
        prev_v   = cur_v;
        cur_p    = t;
        cur_b    = mq.pop_front();
        cur_v    = 1;
        last_pop = t;
        st_q.push_back(t + FLEN + 1);
      end
      if (en && pre < DEPTH) begin
        mq.push_back(d);
        exp_q.push_back(d);
      end
    end
    m_ready = (mq.size() < DEPTH);
    m_tx    = 1'b1;
    m_busy  = 1'b0;
    if (cur_v) begin
      frame_at(cur_p, cur_b, t, act, v);
      if (act) begin m_tx = v; m_busy = 1'b1; end
    end
    if (!m_busy && prev_v) begin
      frame_at(prev_p, prev_b, t, act, v);
      if (act) begin m_tx = v; m_busy = 1'b1; end
    end
    m_status = 1'b0;
    if (st_q.size() > 0 && st_q[0] == t) begin
      m_status = 1'b1;
      void'(st_q.pop_front());
    end
  endtask

  // Samples mid-bit like a far-end receiver and checks each byte against the scoreboard.
  task automatic rx_sample();
    int k;
    if (rx_off < 0) begin
      if (UART_TX === 1'b0) rx_off = 0;
    end else begin
      rx_off++;
    end
    if (rx_off >= 0 && (rx_off % DIV) == DIV / 2) begin
      k = rx_off / DIV;
      if (k >= 1 && k <= 8) rx_sh[k-1] = UART_TX;
      if (k == 9) begin
        chk("rx_stop_bit", UART_TX, 1'b1);
        rx_log.push_back(rx_sh);
        if (exp_q.size() == 0) chk("rx_unexpected_byte", rx_sh, 32'hFFFF_FFFF);
        else chk("rx_byte", rx_sh, exp_q.pop_front());
        rx_off = -1;
      end
    end
  endtask

  task automatic cycle(input logic en, input logic [7:0] d, input logic rst);
    TX_EN   = en;
    TX_DATA = d;
    reset   = rst;
    @(posedge clk);
    model_edge(en, d, rst);
    @(negedge clk);
    chk("uart_tx",   UART_TX,   m_tx);
    chk("tx_busy",   TX_BUSY,   m_busy);
    chk("tx_status", TX_STATUS, m_status);
    chk("overrun",   OVERRUN,   m_ovr);
    chk("tx_ready",  TX_READY,  m_ready);
    rx_sample();
  endtask

  vec_t vecs[8];

  initial begin
    int acc_t, low_t, busy_cnt, stat_cnt, n;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};

    reset   = 1'b1;
    TX_EN   = 1'b0;
    TX_DATA = 8'h00;
    @(negedge clk);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // single byte from idle
    cycle(1'b1, 8'hA5, 1'b0);
    acc_t    = t;
    low_t    = -1;
    busy_cnt = 0;
    stat_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (UART_TX === 1'b0 && low_t < 0) low_t = t;
      if (TX_BUSY === 1'b1) busy_cnt++;
      if (TX_STATUS === 1'b1) stat_cnt++;
    end
    chk("single_latency", low_t - acc_t, 2);
    chk("single_frame_len", busy_cnt, FLEN);
    chk("single_status_pulses", stat_cnt, 1);

    // burst plus overrun while the first frame is in START
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].en, vecs[i].data, vecs[i].rst);
      chk("vec_ready",   TX_READY, vecs[i].exp_ready);
      chk("vec_overrun", OVERRUN,  vecs[i].exp_ovr);
      chk("vec_tx",      UART_TX,  vecs[i].exp_tx);
      chk("vec_busy",    TX_BUSY,  vecs[i].exp_busy);
    end

    // full FIFO with TX_EN held across the pop edge
    n = 0;
    while (TX_READY !== 1'b1 && n < 200) begin
      cycle(1'b1, 8'h66, 1'b0);
      n++;
    end
    chk("full_pop_wait_bound", n < 200, 1'b1);
    chk("full_pop_overrun", OVERRUN, 1'b1);
    chk("full_pop_ready", TX_READY, 1'b1);
    cycle(1'b1, 8'h67, 1'b0);
    chk("after_pop_push_ready", TX_READY, 1'b0);
    chk("after_pop_push_overrun", OVERRUN, 1'b0);
    stat_cnt = 0;
    for (int i = 0; i < 230; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (TX_STATUS === 1'b1) stat_cnt++;
    end
    chk("burst_status_pulses", stat_cnt, 5);
    chk("burst_drained", exp_q.size(), 0);

    // reset during data bit 3
    cycle(1'b1, 8'hC3, 1'b0);
    n = 0;
    while (!(cur_v && (t - cur_p - 1) / DIV == 4) && n < 100) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("reset_wait_bound", n < 100, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("reset_tx", UART_TX, 1'b1);
    chk("reset_busy", TX_BUSY, 1'b0);
    chk("reset_ready", TX_READY, 1'b1);
    busy_cnt = 0;
    low_t    = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (TX_BUSY !== 1'b0) busy_cnt++;
      if (UART_TX !== 1'b1) low_t++;
    end
    chk("reset_quiet_busy", busy_cnt, 0);
    chk("reset_quiet_line", low_t, 0);

    // loopback through the receiver
    rx_log.delete();
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 140; i++) cycle(1'b0, 8'h00, 1'b0);
    chk("loop_count", rx_log.size(), 3);
    if (rx_log.size() == 3) begin
      chk("loop_b0", rx_log[0], 8'h00);
      chk("loop_b1", rx_log[1], 8'hFF);
      chk("loop_b2", rx_log[2], 8'h5A);
    end

    // random traffic with rare resets
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 399) == 0);
    end
    for (int i = 0; i < 250; i++) cycle(1'b0, 8'h00, 1'b0);
    chk("random_drained", exp_q.size(), 0);
    chk("random_rx_idle", rx_off, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
